// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared fetch-path types and default sizing for imem_fetch_ctrl and its skid FIFO.
package fetch_pkg;

  localparam int          ADDR_W     = 32;
  localparam int          DATA_W     = 32;
  localparam int          IMEM_WORDS = 128;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory port, control-unit redirect/halt, decode handshake.
interface imem_fetch_ctrl_if;

  logic [fetch_pkg::ADDR_W-1:0] ImemAddr;
  logic [fetch_pkg::DATA_W-1:0] ImemInstr;
  logic                         Redirect;
  logic [fetch_pkg::ADDR_W-1:0] RedirectPC;
  logic                         Halt;
  logic                         FetchValid;
  logic                         FetchReady;
  logic [fetch_pkg::DATA_W-1:0] FetchInstr;
  logic [fetch_pkg::ADDR_W-1:0] FetchPC;
  logic                         FetchFault;

  modport master (
    output ImemAddr, FetchValid, FetchInstr, FetchPC, FetchFault,
    input  ImemInstr, Redirect, RedirectPC, Halt, FetchReady
  );

  modport slave (
    input  ImemAddr, FetchValid, FetchInstr, FetchPC, FetchFault,
    output ImemInstr, Redirect, RedirectPC, Halt, FetchReady
  );

endinterface

// File: rtl/imem_fetch_ctrl_skid_fifo.sv
// 2-entry {PC,instr} FIFO with flush; head is a register, written 1 cycle after push.
// Pop needs head_vld && head_rdy; a push is dropped only if full without a same-cycle pop.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  fetch_entry_t push_dat,
  input  logic         head_rdy,
  input  logic         flush,
  output logic         head_vld,
  output fetch_entry_t head_dat,
  output logic [1:0]   count
);

  fetch_entry_t ent0_q, ent0_d;
  fetch_entry_t ent1_q, ent1_d;
  logic [1:0]   count_q, count_d;
  logic         pop;
  logic         push_ok;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    pop     = head_rdy && (count_q != 2'd0);
    push_ok = push_vld && ((count_q < 2'd2) || pop);
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push_ok, pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_d = push_dat;
          else                 ent1_d = push_dat;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new entry lands behind whatever survives the pop.
          if (count_q == 2'd1) begin
            ent0_d = push_dat;
          end else begin
            ent0_d = ent1_q;
            ent1_d = push_dat;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign head_vld = (count_q != 2'd0);
  assign head_dat = ent0_q;
  assign count    = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// PC sequencer + RUN/HALT/FAULT FSM feeding a 2-entry skid FIFO; first entry visible 1 cycle after reset release,
// then 1 instr/cycle; fetch stalls (PC holds) when the FIFO is full. Bound/alignment faults with IMEM_BOUND_CHECK_EN.
module imem_fetch_ctrl
  import fetch_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_n,
  imem_fetch_ctrl_if.master   bus
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        count;
  logic              head_vld;
  fetch_entry_t      head_dat;
  fetch_entry_t      push_ent;
  logic              pop;
  logic              push_req;
  logic              push;
  logic              pc_oob;

  assign pop      = head_vld && bus.FetchReady;
  assign push_req = (state_q == RUN) && !bus.Halt && !bus.Redirect && ((count < 2'd2) || pop);

`ifdef IMEM_BOUND_CHECK_EN
  logic fault_q, fault_d;
  assign pc_oob = (pc_q >= ADDR_W'(IMEM_WORDS * 4));
`else
  assign pc_oob = 1'b0;
`endif

  assign push = push_req && !pc_oob;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (push) pc_d = pc_q + ADDR_W'(4);
    if (bus.Redirect) begin
      pc_d    = align_pc(bus.RedirectPC);
      state_d = RUN;
`ifdef IMEM_BOUND_CHECK_EN
      if (bus.RedirectPC[1:0] != 2'b00) state_d = FAULT;
`endif
    end else begin
      unique case (state_q)
        RUN: begin
          if (push_req && pc_oob) state_d = FAULT;
          else if (bus.Halt)      state_d = HALT;
        end
        HALT: begin
          if (!bus.Halt) state_d = RUN;
        end
        default: ;
      endcase
    end
`ifdef IMEM_BOUND_CHECK_EN
    fault_d = (state_d == FAULT);
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
`ifdef IMEM_BOUND_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef IMEM_BOUND_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign push_ent.pc    = pc_q;
  assign push_ent.instr = bus.ImemInstr;

  // Redirect flushes the FIFO; a head pop in the same cycle is subsumed by the flush.
  fetch_skid_fifo u_fifo (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .push_vld (push),
    .push_dat (push_ent),
    .head_rdy (bus.FetchReady),
    .flush    (bus.Redirect),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .count    (count)
  );

  assign bus.ImemAddr   = pc_q;
  assign bus.FetchValid = head_vld;
  assign bus.FetchInstr = head_dat.instr;
  assign bus.FetchPC    = head_dat.pc;
`ifdef IMEM_BOUND_CHECK_EN
  assign bus.FetchFault = fault_q;
`else
  assign bus.FetchFault = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_imem_fetch_ctrl;

`ifdef IMEM_BOUND_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  imem_fetch_ctrl_if bus_if ();

  imem_fetch_ctrl dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus_if)
  );

  logic [31:0] mem [128];
  assign bus_if.ImemInstr = mem[bus_if.ImemAddr[8:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: queue of buffered {pc,instr}, next PC, state 0=run 1=halt 2=fault.
  logic [31:0] mq_pc [$];
  logic [31:0] mq_ins [$];
  logic [31:0] m_pc;
  int          m_state;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return ((pc >> 2) % 128) * 3;
  endfunction

  task automatic model_reset();
    mq_pc.delete();
    mq_ins.delete();
    m_pc    = 32'h0;
    m_state = 0;
  endtask

  task automatic cycle(input logic rdy, input logic hlt, input logic rd, input logic [31:0] rpc);
    bit          pop_m, push_m;
    logic [31:0] dummy;
    bus_if.FetchReady = rdy;
    bus_if.Halt       = hlt;
    bus_if.Redirect   = rd;
    bus_if.RedirectPC = rpc;
    pop_m  = (mq_pc.size() != 0) && rdy;
    push_m = (m_state == 0) && !hlt && !rd && ((mq_pc.size() < 2) || pop_m);
    @(posedge clk);
    if (pop_m) begin
      dummy = mq_pc.pop_front();
      dummy = mq_ins.pop_front();
    end
    if (rd) begin
      mq_pc.delete();
      mq_ins.delete();
      m_pc    = {rpc[31:2], 2'b00};
      m_state = (BC && rpc[1:0] != 2'b00) ? 2 : 0;
    end else if (push_m && BC && m_pc >= 32'd512) begin
      m_state = 2;
    end else begin
      if (push_m) begin
        mq_pc.push_back(m_pc);
        mq_ins.push_back(word_at(m_pc));
        m_pc = m_pc + 32'd4;
      end
      if (m_state == 0 && hlt)       m_state = 1;
      else if (m_state == 1 && !hlt) m_state = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bus_if.FetchReady = 1'b0;
    bus_if.Halt       = 1'b0;
    bus_if.Redirect   = 1'b0;
    bus_if.RedirectPC = 32'h0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus_if.FetchValid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus_if.FetchValid); end
    checks++; if (bus_if.FetchPC !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 0", bus_if.FetchPC); end
    checks++; if (bus_if.FetchInstr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected 0", bus_if.FetchInstr); end
    checks++; if (bus_if.FetchFault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b expected 0", bus_if.FetchFault); end
    checks++; if (bus_if.ImemAddr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", bus_if.ImemAddr); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (bus_if.FetchValid !== 1'b1 || bus_if.FetchPC !== 32'(4 * k) || bus_if.FetchInstr !== 32'(3 * k)) begin
        failures++; $display("FAIL stream[%0d]: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h", k, bus_if.FetchValid, bus_if.FetchPC, bus_if.FetchInstr, 4 * k, 3 * k);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (bus_if.FetchValid !== 1'b1 || bus_if.FetchPC !== 32'h0 || bus_if.FetchInstr !== 32'h0) begin
        failures++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h ins=%h expected v=1 pc=0 ins=0", k, bus_if.FetchValid, bus_if.FetchPC, bus_if.FetchInstr);
      end
    end
    checks++; if (bus_if.ImemAddr !== 32'h8) begin failures++; $display("FAIL bp_addr: got %h expected 8", bus_if.ImemAddr); end
    for (int k = 1; k < 6; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (bus_if.FetchValid !== 1'b1 || bus_if.FetchPC !== 32'(4 * k) || bus_if.FetchInstr !== 32'(3 * k)) begin
        failures++; $display("FAIL bp_resume[%0d]: got v=%b pc=%h ins=%h expected pc=%h ins=%h", k, bus_if.FetchValid, bus_if.FetchPC, bus_if.FetchInstr, 4 * k, 3 * k);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h40);
    checks++; if (bus_if.FetchValid !== 1'b0 || bus_if.ImemAddr !== 32'h40) begin
      failures++; $display("FAIL redir_flush: got v=%b addr=%h expected v=0 addr=40", bus_if.FetchValid, bus_if.ImemAddr);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus_if.FetchValid !== 1'b1 || bus_if.FetchPC !== 32'h40 || bus_if.FetchInstr !== 32'd48) begin
      failures++; $display("FAIL redir_target: got v=%b pc=%h ins=%0d expected v=1 pc=40 ins=48", bus_if.FetchValid, bus_if.FetchPC, bus_if.FetchInstr);
    end
`ifndef IMEM_BOUND_CHECK_EN
    cycle(1'b1, 1'b0, 1'b1, 32'h66);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus_if.FetchPC !== 32'h64 || bus_if.FetchInstr !== 32'd75) begin
      failures++; $display("FAIL redir_mask: got pc=%h ins=%0d expected pc=64 ins=75", bus_if.FetchPC, bus_if.FetchInstr);
    end
`endif
  endtask

  task automatic test_halt();
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (bus_if.FetchValid !== 1'b0 || bus_if.ImemAddr !== 32'hC) begin
        failures++; $display("FAIL halt_drain[%0d]: got v=%b addr=%h expected v=0 addr=c", k, bus_if.FetchValid, bus_if.ImemAddr);
      end
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus_if.FetchValid !== 1'b0 || bus_if.ImemAddr !== 32'hC) begin
      failures++; $display("FAIL halt_exit: got v=%b addr=%h expected v=0 addr=c", bus_if.FetchValid, bus_if.ImemAddr);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus_if.FetchValid !== 1'b1 || bus_if.FetchPC !== 32'hC || bus_if.FetchInstr !== 32'd9) begin
      failures++; $display("FAIL halt_resume: got v=%b pc=%h ins=%0d expected v=1 pc=c ins=9", bus_if.FetchValid, bus_if.FetchPC, bus_if.FetchInstr);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h100);
    checks++; if (bus_if.FetchValid !== 1'b0 || bus_if.ImemAddr !== 32'h100) begin
      failures++; $display("FAIL halt_redir: got v=%b addr=%h expected v=0 addr=100", bus_if.FetchValid, bus_if.ImemAddr);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus_if.FetchValid !== 1'b1 || bus_if.FetchPC !== 32'h100 || bus_if.FetchInstr !== 32'd192) begin
      failures++; $display("FAIL halt_redir_target: got v=%b pc=%h ins=%0d expected v=1 pc=100 ins=192", bus_if.FetchValid, bus_if.FetchPC, bus_if.FetchInstr);
    end
  endtask

  task automatic test_alias();
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 32'h1F8);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus_if.FetchPC !== 32'h1F8 || bus_if.FetchInstr !== 32'd378) begin
      failures++; $display("FAIL alias_1f8: got pc=%h ins=%0d expected pc=1f8 ins=378", bus_if.FetchPC, bus_if.FetchInstr);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus_if.FetchPC !== 32'h1FC || bus_if.FetchInstr !== 32'd381) begin
      failures++; $display("FAIL alias_1fc: got pc=%h ins=%0d expected pc=1fc ins=381", bus_if.FetchPC, bus_if.FetchInstr);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef IMEM_BOUND_CHECK_EN
    checks++; if (bus_if.FetchFault !== 1'b1 || bus_if.FetchValid !== 1'b0) begin
      failures++; $display("FAIL bound_fault: got fault=%b v=%b expected fault=1 v=0", bus_if.FetchFault, bus_if.FetchValid);
    end
    cycle(1'b1, 1'b0, 1'b1, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h42);
    checks++; if (bus_if.FetchFault !== 1'b1) begin failures++; $display("FAIL misalign_fault: got %b expected 1", bus_if.FetchFault); end
    cycle(1'b1, 1'b0, 1'b1, 32'h0);
    checks++; if (bus_if.FetchFault !== 1'b0) begin failures++; $display("FAIL fault_clear: got %b expected 0", bus_if.FetchFault); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus_if.FetchValid !== 1'b1 || bus_if.FetchPC !== 32'h0) begin
      failures++; $display("FAIL fault_restart: got v=%b pc=%h expected v=1 pc=0", bus_if.FetchValid, bus_if.FetchPC);
    end
`else
    checks++; if (bus_if.FetchPC !== 32'h200 || bus_if.FetchInstr !== 32'd0 || bus_if.FetchFault !== 1'b0) begin
      failures++; $display("FAIL alias_200: got pc=%h ins=%0d fault=%b expected pc=200 ins=0 fault=0", bus_if.FetchPC, bus_if.FetchInstr, bus_if.FetchFault);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus_if.FetchPC !== 32'h204 || bus_if.FetchInstr !== 32'd3) begin
      failures++; $display("FAIL alias_204: got pc=%h ins=%0d expected pc=204 ins=3", bus_if.FetchPC, bus_if.FetchInstr);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus_if.FetchValid !== 1'b0 || bus_if.ImemAddr !== 32'h0 || bus_if.FetchPC !== 32'h0) begin
      failures++; $display("FAIL async_reset: got v=%b addr=%h pc=%h expected v=0 addr=0 pc=0", bus_if.FetchValid, bus_if.ImemAddr, bus_if.FetchPC);
    end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus_if.FetchValid !== 1'b1 || bus_if.FetchPC !== 32'h0 || bus_if.FetchInstr !== 32'h0) begin
      failures++; $display("FAIL async_restart: got v=%b pc=%h ins=%h expected v=1 pc=0 ins=0", bus_if.FetchValid, bus_if.FetchPC, bus_if.FetchInstr);
    end
  endtask

  task automatic test_random();
    logic hlt;
    logic rdy, rd;
    logic [31:0] rpc;
    do_reset();
    hlt = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      rdy = ($urandom % 4) != 0;
      if (($urandom % 10) == 0) hlt = ~hlt;
      rd  = ($urandom % 16) == 0;
      rpc = 32'($urandom_range(0, 32'h3FF));
      cycle(rdy, hlt, rd, rpc);
      checks++; if (bus_if.FetchValid !== (mq_pc.size() != 0)) begin
        failures++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, bus_if.FetchValid, mq_pc.size() != 0);
      end
      if (mq_pc.size() != 0) begin
        checks++; if (bus_if.FetchPC !== mq_pc[0] || bus_if.FetchInstr !== mq_ins[0]) begin
          failures++; $display("FAIL rnd_head[%0d]: got pc=%h ins=%h expected pc=%h ins=%h", n, bus_if.FetchPC, bus_if.FetchInstr, mq_pc[0], mq_ins[0]);
        end
      end
      if (m_state != 2) begin
        checks++; if (bus_if.ImemAddr !== m_pc) begin
          failures++; $display("FAIL rnd_addr[%0d]: got %h expected %h", n, bus_if.ImemAddr, m_pc);
        end
      end
      checks++; if (bus_if.FetchFault !== (m_state == 2)) begin
        failures++; $display("FAIL rnd_fault[%0d]: got %b expected %b", n, bus_if.FetchFault, m_state == 2);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks            = 0;
    failures          = 0;
    rst_n             = 1'b0;
    bus_if.FetchReady = 1'b0;
    bus_if.Halt       = 1'b0;
    bus_if.Redirect   = 1'b0;
    bus_if.RedirectPC = 32'h0;
    for (int i = 0; i < 128; i++) mem[i] = 32'(i * 3);
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_alias();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
